// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: CHUNK-bit-per-stage pipelined add/subtract with N/Z/C/V flags; ADDSUB_SATURATE_EN adds signed saturation
module pipelined_add_sub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic             r_v   [NMID];
    logic [WIDTH-1:0] r_a   [NMID];
    logic [WIDTH-1:0] r_b   [NMID];
    logic [WIDTH-1:0] r_s   [NMID];
    logic             r_c   [NMID];
    logic             r_sat [NMID];

    logic             w_v   [STAGES];
    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_s   [STAGES];
    logic             w_c   [STAGES];
    logic             w_co  [STAGES];
    logic             w_sa  [STAGES];

    logic             w_stall;
    logic             w_sat0;
    logic             w_cin_msb;
    logic             w_ov;
    logic [WIDTH-1:0] w_res;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

`ifdef ADDSUB_SATURATE_EN
    assign w_sat0 = sat;
`else
    assign w_sat0 = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_sp;
        logic [WIDTH-1:0] w_sum;
        logic [CHUNK:0]   w_add;
        if (k == 0) begin : g_first
            assign w_v[k]  = in_valid & in_ready;
            assign w_a[k]  = a;
            assign w_b[k]  = sub ? ~b : b;
            assign w_c[k]  = sub;
            assign w_sa[k] = w_sat0;
            assign w_sp    = '0;
        end else begin : g_next
            assign w_v[k]  = r_v[k-1];
            assign w_a[k]  = r_a[k-1];
            assign w_b[k]  = r_b[k-1];
            assign w_c[k]  = r_c[k-1];
            assign w_sa[k] = r_sat[k-1];
            assign w_sp    = r_s[k-1];
        end
        assign w_add = {1'b0, w_a[k][k*CHUNK +: CHUNK]} + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                     + (CHUNK+1)'(w_c[k]);
        // Splice this stage's slice into the partial sum carried from earlier stages
        always_comb begin
            w_sum = w_sp;
            w_sum[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
        end
        assign w_s[k]  = w_sum;
        assign w_co[k] = w_add[CHUNK];
    end

    // Carry into the MSB is recovered from the MSB sum bit; overflow needs it with the carry out
    assign w_cin_msb = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1] ^ w_s[STAGES-1][WIDTH-1];
    assign w_ov      = w_cin_msb ^ w_co[STAGES-1];
    assign w_res     = (w_sa[STAGES-1] & w_ov) ? (w_a[STAGES-1][WIDTH-1] ? ~SMAX : SMAX)
                                               : w_s[STAGES-1];

    // Intermediate stages advance in lockstep; a stall freezes them all
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NMID; i++) begin
                r_v[i]   <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_s[i]   <= '0;
                r_c[i]   <= 1'b0;
                r_sat[i] <= 1'b0;
            end
        end else if (!w_stall) begin
            for (int i = 0; i < STAGES - 1; i++) begin
                r_v[i]   <= w_v[i];
                r_a[i]   <= w_a[i];
                r_b[i]   <= w_b[i];
                r_s[i]   <= w_s[i];
                r_c[i]   <= w_co[i];
                r_sat[i] <= w_sa[i];
            end
        end
    end

    // Final stage registers the result together with its flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carryOut  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (!w_stall) begin
            out_valid <= w_v[STAGES-1];
            result    <= w_res;
            carryOut  <= w_co[STAGES-1];
            overflow  <= w_ov;
            zero      <= (w_res == '0);
            negative  <= w_res[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed vectors with a queued scoreboard and a decoupled output monitor
module tb_pipelined_add_sub;
    localparam int STG = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          when;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        carryOut, overflow, zero, negative;
`ifdef ADDSUB_SATURATE_EN
    logic        sat = 1'b0;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t exp_q[$];

    pipelined_add_sub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryOut(carryOut), .overflow(overflow), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output transfer is checked against the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got result=%h at cycle %0d, required no output", result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({result, carryOut, overflow, zero, negative} !== {e.r, e.c, e.v, e.z, e.n}) begin
                    n_fail++;
                    $display("FAIL result_flags: got %h c%b v%b z%b n%b, required %h c%b v%b z%b n%b",
                             result, carryOut, overflow, zero, negative, e.r, e.c, e.v, e.z, e.n);
                end
                if (e.when >= 0) begin
                    n_tests++;
                    if (cyc != e.when) begin
                        n_fail++;
                        $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, e.when);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [63:0] ta, input logic [63:0] tb_b, input logic ts,
                        input logic [63:0] er, input logic ec, input logic ev,
                        input logic ez, input logic en, input logic timed);
        a = ta;
        b = tb_b;
        sub = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{er, ec, ev, ez, en, timed ? cyc + STG - 1 : -1});
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, result, carryOut, overflow, zero},
              {1'b0, 64'h0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        #1;
        check("ready_after_reset", {67'h0, in_ready}, 68'h1);
        check("negative_after_reset", {67'h0, negative}, 68'h0);
        @(posedge clk);
        #1;

        // Boundary vectors, issued back to back
        send(64'd30, 64'd30, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(64'd0, 64'd1, 1'b1, ONES, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(ONES, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Eight consecutive ops: even i adds (3i), odd i subtracts (-i)
        for (int i = 0; i < 8; i++) begin
            logic [63:0] av, bv, rv;
            av = 64'(i);
            bv = 64'(2 * i);
            rv = (i % 2 == 1) ? -av : 64'(3 * i);
            send(av, bv, i[0], rv, 1'b0, 1'b0, i == 0, i[0], 1'b1);
        end
        drain();

        // Backpressure: four results pending, consumer stalls for three cycles
        out_ready = 1'b0;
        send(64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'd10, 64'd3, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'd5, 64'd5, 1'b0, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(64'd2, 64'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        a = 64'd4;
        b = 64'd4;
        sub = 1'b1;
        check("stall_in_ready", {67'h0, in_ready}, 68'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {in_ready, out_valid, result, carryOut, overflow},
                  {1'b0, 1'b1, 64'd3, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(64'd4, 64'd4, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset while operations are in flight and one result is stalled at the output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_reset_valid", {67'h0, out_valid}, 68'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clear", {out_valid, result, carryOut, overflow, zero},
              {1'b0, 64'h0, 1'b0, 1'b0, 1'b0});
        check("async_reset_neg", {66'h0, negative, in_ready}, 68'h1);
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(64'd100, 64'd1, 1'b1, 64'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the 64-bit ripple add/subtract unit.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Produces result plus N/Z/C/V flags for the datapath and flag register.
- Uses a valid/ready handshake so it can sit behind the register-file read stage and accept a new operation every cycle.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per pipeline stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op presented this cycle
- in_ready  output  1  unit can accept an operation this cycle
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- sub  input  1  0 = a+b, 1 = a-b (computed as a + ~b + 1)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- carryOut  output  1  carry out of MSB; for subtract this is NOT borrow (1 when a >= b unsigned)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]

Behaviour:
- Reset is asynchronous and active-high; it clears every stage valid bit, result, all flags and out_valid to 0. in_ready reads 1 once reset is low.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stage 0 at the input transfer:
  - b is inverted when sub=1; the initial carry-in = sub.
  - Slice 0 is added and its sum bits and carry are registered.
  - The upper slices of a and the conditioned b are registered unchanged.
- Stage k (1..STAGES-1) adds slice k using the registered carry from stage k-1. The lower sum slices propagate forward unchanged.
- For the final slice, the carry into bit WIDTH-1 and the carry out of bit WIDTH-1 are both kept to form overflow.
- Flags are computed from the final-stage sum and registered together with result, so all outputs are registered.
- Latency: out_valid asserts STAGES cycles after the input transfer when there is no stall. Throughput is 1 op/cycle.
- Stall is global:
  - stall = out_valid & ~out_ready.
  - While stall is high, every stage register holds and in_ready = 0.
  - in_ready = ~stall, combinational from out_valid and out_ready.
- A bubble (in_valid=0 at an accepted cycle) propagates as an invalid stage. Bubbles are not compressed.
- Simultaneous output transfer and new input: allowed; both complete in the same cycle.
- Results hold stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all in-flight operations; no partial result is ever output.
- STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.
- Ordering: results leave in acceptance order; no reordering.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- When defined:
  - Adds input sat (1 bit), captured with the operation and carried down the pipeline.
  - If sat=1 and overflow=1, result is clamped to the signed max (0x7FFF…F) when the true sign is positive (a non-negative), or the signed min (0x8000…0) otherwise.
  - overflow still reports 1; carryOut is unchanged; zero and negative reflect the clamped result.
- When not defined: no sat port; results always wrap modulo 2^WIDTH.

Test Plan:
- WIDTH=64, CHUNK=16: a=30, b=30, sub=1 -> after 4 cycles result=0, zero=1, carryOut=1, overflow=0, negative=0.
- a=0x7FFFFFFFFFFFFFFF, b=1, sub=0 -> result=0x8000000000000000, overflow=1, negative=1, carryOut=0; with the macro defined and sat=1 -> result=0x7FFFFFFFFFFFFFFF, overflow=1.
- a=0, b=1, sub=1 -> result=0xFFFFFFFFFFFFFFFF, carryOut=0, negative=1, overflow=0. a=0xFFFFFFFFFFFFFFFF, b=1, sub=0 -> result=0, carryOut=1, zero=1 (carry ripples across all stage boundaries).
- Back-to-back: 8 consecutive ops (a=i, b=2*i, alternating sub) with out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle 4, in order, each matching the reference model.
- Backpressure: hold out_ready=0 for 3 cycles while results are pending -> in_ready=0, result and flags stable, no loss or duplication; release -> remaining results drain in order.
- Reset pulsed while 3 ops are in flight -> out_valid=0 and all outputs 0 immediately (asynchronously); the first op accepted after reset appears exactly 4 cycles later.
